// File: rtl/rr_responder_if.sv
// rr_bus request/response interface: an initiator issues one request and
// waits for the matching response from the responder.
interface rr_bus #(
  parameter int AW = 2,
  parameter int DW = 8
) ();
  logic          req_valid;
  logic          req_ready;
  logic          req_write;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          resp_valid;
  logic          resp_ready;
  logic [DW-1:0] resp_rdata;

  modport responder (
    input  req_valid, req_write, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata
  );

  modport initiator (
    output req_valid, req_write, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata
  );
endinterface

// File: rtl/rr_responder.sv
// Single-outstanding responder on rr_bus: a small register file, a fixed
// response latency and a wrapping count of completed transactions.
//
// state | meaning
// IDLE  | ready for a request (req_ready=1)
// BUSY  | latency countdown, request side ignored
// RESP  | response presented, waiting for resp_ready
module rr_responder #(
  parameter int LATENCY = 2,
  parameter int AW      = 2,
  parameter int DW      = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  rr_bus.responder   bus,
  output logic [7:0] done_count
);

  localparam int DEPTH = 1 << AW;
  localparam int CNT_INIT_I = (LATENCY > 0) ? LATENCY - 1 : 0;
  localparam logic [3:0] CNT_INIT = CNT_INIT_I[3:0];

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t        state_q;
  logic [3:0]    cnt_q;
  logic [DW-1:0] rdata_q;
  logic [7:0]    done_q;
  logic [DW-1:0] mem_q [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rdata_q <= '0;
      done_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.req_valid) begin
            if (bus.req_write) begin
              mem_q[bus.req_addr] <= bus.req_wdata;
              rdata_q             <= bus.req_wdata;
            end else begin
              rdata_q <= mem_q[bus.req_addr];
            end
            cnt_q <= CNT_INIT;
            // Zero latency skips the countdown entirely.
            if (LATENCY == 0) state_q <= RESP;
            else              state_q <= BUSY;
          end
        end
        BUSY: begin
          if (cnt_q == 4'd0) state_q <= RESP;
          else               cnt_q   <= cnt_q - 4'd1;
        end
        RESP: begin
          if (bus.resp_ready) begin
            state_q <= IDLE;
            done_q  <= done_q + 8'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.req_ready  = (state_q == IDLE);
  assign bus.resp_valid = (state_q == RESP);
  assign bus.resp_rdata = (state_q == RESP) ? rdata_q : '0;
  assign done_count     = done_q;

endmodule

// File: tb/tb_rr_responder.sv
// Randomized bench for rr_responder: one LATENCY=2 and one LATENCY=0 instance,
// selected by sel, checked against an array/counter model of the bus contract.
module tb_rr_responder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       sel = 1'b0;
  logic       req_valid = 1'b0, req_write = 1'b0, resp_ready = 1'b0;
  logic [1:0] req_addr = '0;
  logic [7:0] req_wdata = '0;
  logic [7:0] done2, done0;

  rr_bus #(.AW(2), .DW(8)) b2 ();
  rr_bus #(.AW(2), .DW(8)) b0 ();

  assign b2.req_valid  = req_valid & ~sel;
  assign b2.resp_ready = resp_ready & ~sel;
  assign b2.req_write  = req_write;
  assign b2.req_addr   = req_addr;
  assign b2.req_wdata  = req_wdata;
  assign b0.req_valid  = req_valid & sel;
  assign b0.resp_ready = resp_ready & sel;
  assign b0.req_write  = req_write;
  assign b0.req_addr   = req_addr;
  assign b0.req_wdata  = req_wdata;

  rr_responder #(.LATENCY(2), .AW(2), .DW(8)) dut2 (
    .clk(clk), .rst_n(rst_n), .bus(b2.responder), .done_count(done2));
  rr_responder #(.LATENCY(0), .AW(2), .DW(8)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(b0.responder), .done_count(done0));

  wire       req_ready_o  = sel ? b0.req_ready  : b2.req_ready;
  wire       resp_valid_o = sel ? b0.resp_valid : b2.resp_valid;
  wire [7:0] resp_rdata_o = sel ? b0.resp_rdata : b2.resp_rdata;
  wire [7:0] done_o       = sel ? done0 : done2;

  // Model: per-instance register file contents and completed-transaction count.
  int  mem_m [2][4];
  int  done_m [2];
  time last_acc [2];
  int  n_chk = 0, n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      done_m[d] = 0;
      for (int a = 0; a < 4; a++) mem_m[d][a] = 0;
    end
  endtask

  task automatic junk();
    req_valid = 1'($urandom_range(0, 1));
    req_write = 1'($urandom_range(0, 1));
    req_addr  = 2'($urandom_range(0, 3));
    req_wdata = 8'($urandom_range(0, 255));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  task automatic txn(input bit wr, input logic [1:0] addr, input logic [7:0] wd,
                     input int hold, input bit b2b);
    int s, lat, n;
    bit seen;
    logic [7:0] exp_d;
    time acc_t;
    s   = sel ? 1 : 0;
    lat = sel ? 0 : 2;
    chk("req_ready_idle", req_ready_o, 1);
    exp_d = wr ? wd : 8'(mem_m[s][addr]);
    if (wr) mem_m[s][addr] = wd;
    req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wd;
    resp_ready = (hold == 0);
    @(posedge clk);
    acc_t = $time;
    if (b2b) chk("b2b_spacing", 32'((acc_t - last_acc[s]) / 10), lat + 2);
    last_acc[s] = acc_t;
    n = 0; seen = 0;
    while (!seen && n < 40) begin
      @(negedge clk);
      n++;
      if (resp_valid_o) seen = 1;
      else chk("rdata_zero_busy", resp_rdata_o, 0);
      junk();
    end
    if (!seen) begin
      chk("resp_timeout", 0, 1);
      req_valid = 1'b0;
      return;
    end
    chk("resp_latency", n, lat + 1);
    chk("resp_rdata", resp_rdata_o, exp_d);
    chk("req_ready_resp", req_ready_o, 0);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("hold_valid", resp_valid_o, 1);
      chk("hold_rdata", resp_rdata_o, exp_d);
      chk("hold_req_ready", req_ready_o, 0);
      junk();
    end
    resp_ready = 1'b1;
    @(posedge clk);
    done_m[s] = (done_m[s] + 1) % 256;
    @(negedge clk);
    req_valid = 1'b0;
    chk("post_valid", resp_valid_o, 0);
    chk("post_req_ready", req_ready_o, 1);
    chk("post_rdata", resp_rdata_o, 0);
    chk("done_count", done_o, done_m[s]);
  endtask

  initial begin
    model_reset();
    last_acc[0] = 0; last_acc[1] = 0;
    do_reset();
    for (int d = 0; d < 2; d++) begin
      sel = d[0];
      #1;
      chk("rst_req_ready", req_ready_o, 1);
      chk("rst_resp_valid", resp_valid_o, 0);
      chk("rst_rdata", resp_rdata_o, 0);
      chk("rst_done", done_o, 0);
    end
    sel = 1'b0;
    @(negedge clk);

    txn(1'b1, 2'd1, 8'hA5, 0, 1'b0);
    txn(1'b0, 2'd1, 8'h00, 0, 1'b1);
    chk("wr_rd_done", done_o, 2);
    txn(1'b0, 2'd2, 8'h00, 5, 1'b0);

    sel = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 4; i++)
      txn(1'b1, 2'(i), 8'($urandom_range(0, 255)), 0, i > 0);
    chk("lat0_done", done_o, 4);

    for (int i = 0; i < 60; i++) begin
      sel = 1'($urandom_range(0, 1));
      #1;
      txn(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
          8'($urandom_range(0, 255)), $urandom_range(0, 3), 1'b0);
    end

    sel = 1'b1;
    do_reset();
    @(negedge clk);
    for (int i = 0; i < 257; i++)
      txn(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
          8'($urandom_range(0, 255)), 0, i > 0);
    chk("wrap_done", done_o, 1);

    sel = 1'b0;
    #1;
    req_valid = 1'b1; req_write = 1'b1; req_addr = 2'd0; req_wdata = 8'h3C;
    resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    chk("busy_before_rst", resp_valid_o, 0);
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("rst_mid_valid", resp_valid_o, 0);
    chk("rst_mid_ready", req_ready_o, 1);
    chk("rst_mid_done", done_o, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    txn(1'b0, 2'd0, 8'h00, 0, 1'b0);
    chk("rst_mid_done_after", done_o, 1);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
